// File: rtl/grayscale_to_rgb_stream_if.sv
// Stream interfaces for the grayscale-to-RGB converter.
// Grayscale pixels enter on gray_stream_if; mapped colour leaves on rgb_stream_if.
`timescale 1ns/1ps

interface gray_stream_if #(
    parameter int GRAY_W = 10
);
    logic              valid;
    logic              ready;
    logic [GRAY_W-1:0] gray;
    logic              sof;
    logic              eol;

    modport master (output valid, gray, sof, eol, input ready);
    modport slave  (input valid, gray, sof, eol, output ready);
endinterface

interface rgb_stream_if #(
    parameter int COL_W = 8
);
    logic             valid;
    logic             ready;
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
    logic             sof;
    logic             eol;

    modport master (output valid, r, g, b, sof, eol, input ready);
    modport slave  (input valid, r, g, b, sof, eol, output ready);
endinterface

// File: rtl/grayscale_to_rgb_stream.sv
// Maps 10-bit grayscale pixels back to 8-bit RGB through a 2-stage elastic pipeline.
// Stage 1 clips and scales; stage 2 applies the per-frame colour map.
`timescale 1ns/1ps

module grayscale_to_rgb_stream #(
    parameter int GRAY_W   = 10,
    parameter int COL_W    = 8,
    parameter int GRAY_MAX = 1020,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             sat_clr,
    gray_stream_if.slave     s,
    rgb_stream_if.master     m,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             sat_flag
);

    typedef enum logic [1:0] {
        MAP_GRAY   = 2'd0,
        MAP_HEAT   = 2'd1,
        MAP_JET    = 2'd2,
        MAP_INVERT = 2'd3
    } map_mode_t;

    localparam logic [GRAY_W-1:0] GRAY_MAX_V = GRAY_W'(GRAY_MAX);

    map_mode_t        mode_q;

    logic             s1_valid;
    logic [COL_W-1:0] s1_g8;
    map_mode_t        s1_mode;
    logic             s1_sof;
    logic             s1_eol;

    logic             s2_valid;
    logic [COL_W-1:0] s2_r;
    logic [COL_W-1:0] s2_g;
    logic [COL_W-1:0] s2_b;
    logic             s2_sof;
    logic             s2_eol;

    logic             s2_adv;
    logic             s1_adv;
    logic             s_fire;
    logic             over_max;
    logic [GRAY_W-1:0] gray_clip;
    map_mode_t        mode_in;

    logic [COL_W-1:0] map_r;
    logic [COL_W-1:0] map_g;
    logic [COL_W-1:0] map_b;
    logic [COL_W-1:0] dbl;
    logic             upper;

    assign s2_adv    = !s2_valid || m.ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign s.ready   = rst_n && s1_adv;
    assign s_fire    = s.valid && s.ready;
    assign over_max  = s.gray > GRAY_MAX_V;
    assign gray_clip = over_max ? GRAY_MAX_V : s.gray;
    // A start-of-frame beat already uses the mode presented alongside it.
    assign mode_in   = s.sof ? map_mode_t'(mode) : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MAP_GRAY;
            s1_valid <= 1'b0;
            s1_g8    <= '0;
            s1_mode  <= MAP_GRAY;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
        end else begin
            if (s_fire && s.sof) begin
                mode_q <= map_mode_t'(mode);
            end
            if (s1_adv) begin
                s1_valid <= s_fire;
            end
            if (s_fire) begin
                s1_g8   <= gray_clip[GRAY_W-1 -: COL_W];
                s1_mode <= mode_in;
                s1_sof  <= s.sof;
                s1_eol  <= s.eol;
            end
        end
    end

    // Saturation is sticky; a new over-range beat outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s_fire && over_max) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    // Doubling the low seven bits gives both 2*g8 and 2*(g8-128); 255-x is ~x.
    assign dbl   = {s1_g8[COL_W-2:0], 1'b0};
    assign upper = s1_g8[COL_W-1];

    always_comb begin
        map_r = s1_g8;
        map_g = s1_g8;
        map_b = s1_g8;
        case (s1_mode)
            MAP_HEAT: begin
                map_r = upper ? '1 : dbl;
                map_g = upper ? dbl : '0;
                map_b = '0;
            end
            MAP_JET: begin
                map_r = upper ? dbl : '0;
                map_g = upper ? ~dbl : dbl;
                map_b = upper ? '0 : ~dbl;
            end
            MAP_INVERT: begin
                map_r = ~s1_g8;
                map_g = ~s1_g8;
                map_b = ~s1_g8;
            end
            default: begin
                map_r = s1_g8;
                map_g = s1_g8;
                map_b = s1_g8;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r   <= map_r;
                s2_g   <= map_g;
                s2_b   <= map_b;
                s2_sof <= s1_sof;
                s2_eol <= s1_eol;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (s2_valid && m.ready && s2_sof) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign m.valid = s2_valid;
    assign m.r     = s2_r;
    assign m.g     = s2_g;
    assign m.b     = s2_b;
    assign m.sof   = s2_sof;
    assign m.eol   = s2_eol;

endmodule
